// File: rtl/au_pkg.sv
// Shared types and helpers for the arithmetic-unit normaliser.
// Holds the FSM state encoding and a constant clog2.
package au_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/au_lead_sign_step.sv
// Leading-sign counter over a small window of the shift register.
// Counts copies of the top bit directly below it, saturating at STEP.
module au_lead_sign_step
    import au_pkg::*;
#(
    parameter int STEP = 1,
    parameter int LW   = 1
) (
    input  logic [STEP:0] t,
    output logic [LW-1:0] loc
);

    // walk down from the sign bit, stop counting at the first differing bit
    always_comb begin
        logic run;
        loc = '0;
        run = 1'b1;
        for (int i = STEP - 1; i >= 0; i--) begin
            if (run && (t[i] == t[STEP])) begin
                loc = loc + LW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/au_lead_sign_norm.sv
// Sequential two's-complement normaliser with ready/valid on both sides.
// Shifts up to STEP redundant sign bits out per cycle and reports the count.
module au_lead_sign_norm
    import au_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int STEP  = 1,
    localparam int CW    = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic [CW-1:0]    cnt,
    output logic             all_sign
);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    loc;
    logic [CW:0]      room;
    logic [CW:0]      k;
    logic [CW:0]      sum;
    logic             fin;
    logic             accept;

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign z         = sreg;

    au_lead_sign_step #(
        .STEP(STEP),
        .LW  (CW)
    ) u_step (
        .t  (sreg[WIDTH-1 -: STEP+1]),
        .loc(loc)
    );

    // shift amount this cycle, clamped so cnt never passes WIDTH-1
    always_comb begin
        room = (CW+1)'(WIDTH - 1) - {1'b0, cnt};
        k    = ({1'b0, loc} < room) ? {1'b0, loc} : room;
        sum  = {1'b0, cnt} + k;
        fin  = (loc < CW'(STEP)) | (sum == (CW+1)'(WIDTH - 1));
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = BUSY;
            BUSY: if (fin) state_nx = DONE;
            DONE: if (out_ready) state_nx = in_valid ? BUSY : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // load on accept, shift while busy, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg     <= '0;
            cnt      <= '0;
            all_sign <= 1'b0;
        end else if (accept) begin
            sreg     <= a;
            cnt      <= '0;
            all_sign <= (a == {WIDTH{a[0]}});
        end else if (state == BUSY) begin
            sreg     <= sreg << k;
            cnt      <= sum[CW-1:0];
        end
    end

endmodule

// File: tb/tb_au_lead_sign_norm.sv
// Bench for au_lead_sign_norm at WIDTH=8 with STEP=1 and STEP=3.
// Expected results come from a leading-sign reference model.
module tb_au_lead_sign_norm;

    typedef struct packed {
        logic [7:0]  z;
        logic [2:0]  c;
        logic        as;
        logic [31:0] lat;
        logic [31:0] e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = 8'h00;

    logic       rdy1, ov1, as1;
    logic       rdy3, ov3, as3;
    logic [7:0] z1, z3;
    logic [2:0] c1, c3;

    int         sel = 0;
    int         checks = 0;
    int         passes = 0;
    int         edges = 0;
    int         done_cnt = 0;
    bit         seen = 0;
    exp_t       sb[$];
    logic [7:0] stim[$];

    wire       c_rdy = (sel == 1) ? rdy3 : rdy1;
    wire       c_ov  = (sel == 1) ? ov3 : ov1;
    wire [7:0] c_z   = (sel == 1) ? z3 : z1;
    wire [2:0] c_c   = (sel == 1) ? c3 : c1;
    wire       c_as  = (sel == 1) ? as3 : as1;

    always #5 clk = ~clk;

    always @(posedge clk) edges++;

    au_lead_sign_norm #(.WIDTH(8), .STEP(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .a(a), .out_valid(ov1), .out_ready(out_ready),
        .z(z1), .cnt(c1), .all_sign(as1)
    );

    au_lead_sign_norm #(.WIDTH(8), .STEP(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3),
        .a(a), .out_valid(ov3), .out_ready(out_ready),
        .z(z3), .cnt(c3), .all_sign(as3)
    );

    // reference: p = highest bit position differing from the sign bit
    function automatic exp_t gold(input logic [7:0] x, input int step,
                                  input int e);
        exp_t r;
        int   s;
        s = 7;
        for (int i = 0; i <= 6; i++) begin
            if (x[i] != x[7]) s = 6 - i;
        end
        r.z   = x << s;
        r.c   = 3'(s);
        r.as  = (s == 7);
        r.lat = (s == 7) ? 32'((7 + step - 1) / step) : 32'(s / step + 1);
        r.e   = 32'(e);
        return r;
    endfunction

    // one clock of stimulus plus scoreboard push/pop for the selected DUT
    task automatic cycle(input bit v, input logic [7:0] d, input bit r,
                         output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        a         = d;
        out_ready = r;
        #2;
        acc = v && c_rdy;
        if (!rst) begin
            if (c_ov && !seen && sb.size() > 0) begin
                seen = 1;
                checks++;
                if (32'(edges) - sb[0].e !== sb[0].lat)
                    $display("FAIL latency: got %0d want %0d",
                             32'(edges) - sb[0].e, sb[0].lat);
                else passes++;
            end
            if (c_ov && r) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_out: got z=%h want none", c_z);
                end else begin
                    passes++;
                    e = sb.pop_front();
                    seen = 0;
                    done_cnt++;
                    checks++;
                    if (c_z !== e.z)
                        $display("FAIL z: got %h want %h", c_z, e.z);
                    else passes++;
                    checks++;
                    if (c_c !== e.c)
                        $display("FAIL cnt: got %0d want %0d", c_c, e.c);
                    else passes++;
                    checks++;
                    if (c_as !== e.as)
                        $display("FAIL all_sign: got %b want %b", c_as, e.as);
                    else passes++;
                end
            end
            if (acc) sb.push_back(gold(d, (sel == 1) ? 3 : 1, edges + 1));
        end
    endtask

    task automatic stream(input int vp, input int rp, input int budget,
                          output bit ok);
        int n;
        bit acc;
        bit v;
        n = 0;
        while ((stim.size() > 0 || sb.size() > 0) && n < budget) begin
            v = (stim.size() > 0) && ($urandom_range(1, 100) <= vp);
            cycle(v, v ? stim[0] : 8'($urandom),
                  $urandom_range(1, 100) <= rp, acc);
            if (acc) void'(stim.pop_front());
            n++;
        end
        ok = (stim.size() == 0) && (sb.size() == 0);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(1'b0, 8'h00, 1'b1, acc);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({ov1, z1, c1, as1, rdy1} !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b1})
            $display("FAIL reset_s1: got %b want %b",
                     {ov1, z1, c1, as1, rdy1}, {1'b0, 8'h00, 3'd0, 1'b0, 1'b1});
        else passes++;
        checks++;
        if ({ov3, z3, c3, as3, rdy3} !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b1})
            $display("FAIL reset_s3: got %b want %b",
                     {ov3, z3, c3, as3, rdy3}, {1'b0, 8'h00, 3'd0, 1'b0, 1'b1});
        else passes++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed(input int s, input logic [7:0] w0,
                                 input logic [7:0] w1, input logic [7:0] w2,
                                 input logic [7:0] w3, input logic [7:0] w4);
        bit ok;
        int d0;
        sel = s;
        seen = 0;
        d0 = done_cnt;
        stim = '{w0, w1, w2, w3, w4};
        stream(100, 100, 200, ok);
        checks++;
        if (!ok) $display("FAIL directed_timeout: got %0d left want 0",
                          stim.size() + sb.size());
        else passes++;
        checks++;
        if (done_cnt - d0 !== 5)
            $display("FAIL directed_count: got %0d want 5", done_cnt - d0);
        else passes++;
        idle(30);
    endtask

    task automatic test_backpressure();
        bit acc;
        int n;
        logic [11:0] held;
        sel = 0;
        seen = 0;
        cycle(1'b1, 8'h0F, 1'b0, acc);
        checks++;
        if (acc !== 1'b1) $display("FAIL bp_accept: got %b want 1", acc);
        else passes++;
        n = 0;
        do begin
            cycle(1'b0, 8'h00, 1'b0, acc);
            n++;
        end while (!c_ov && n < 20);
        checks++;
        if (!c_ov) $display("FAIL bp_wait: got timeout want out_valid");
        else passes++;
        held = {c_z, c_c, c_as};
        checks++;
        if (held !== {8'h78, 3'd3, 1'b0})
            $display("FAIL bp_result: got %h want %h", held, {8'h78, 3'd3, 1'b0});
        else passes++;
        repeat (5) begin
            cycle(1'b1, 8'h03, 1'b0, acc);
            checks++;
            if ({c_ov, c_rdy, c_z, c_c, c_as} !== {1'b1, 1'b0, held})
                $display("FAIL bp_hold: got %h want %h",
                         {c_ov, c_rdy, c_z, c_c, c_as}, {1'b1, 1'b0, held});
            else passes++;
        end
        cycle(1'b1, 8'h03, 1'b1, acc);
        checks++;
        if (acc !== 1'b1) $display("FAIL bp_handoff: got %b want 1", acc);
        else passes++;
        n = 0;
        while (sb.size() > 0 && n < 30) begin
            cycle(1'b0, 8'h00, 1'b1, acc);
            n++;
        end
        checks++;
        if (sb.size() != 0) $display("FAIL bp_drain: got %0d want 0", sb.size());
        else passes++;
        idle(30);
    endtask

    task automatic test_reset_mid_busy();
        bit acc;
        bit ok;
        sel = 0;
        seen = 0;
        cycle(1'b1, 8'h00, 1'b1, acc);
        cycle(1'b0, 8'h00, 1'b1, acc);
        cycle(1'b0, 8'h00, 1'b1, acc);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({c_ov, c_z, c_c, c_as, c_rdy} !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b1})
            $display("FAIL mid_reset: got %b want %b",
                     {c_ov, c_z, c_c, c_as, c_rdy}, {1'b0, 8'h00, 3'd0, 1'b0, 1'b1});
        else passes++;
        sb.delete();
        seen = 0;
        #3 rst = 1'b0;
        stim = '{8'h0F, 8'h00, 8'h7F};
        stream(100, 100, 100, ok);
        checks++;
        if (!ok) $display("FAIL post_reset: got %0d left want 0",
                          stim.size() + sb.size());
        else passes++;
        idle(30);
    endtask

    task automatic test_random(input int s, input int nw);
        bit ok;
        int d0;
        logic signed [7:0] r;
        sel = s;
        seen = 0;
        d0 = done_cnt;
        stim.delete();
        for (int i = 0; i < nw; i++) begin
            r = 8'($urandom);
            r = r >>> $urandom_range(0, 7);
            stim.push_back(r);
        end
        stream(70, 70, 30000, ok);
        checks++;
        if (!ok) $display("FAIL random_timeout: got %0d left want 0",
                          stim.size() + sb.size());
        else passes++;
        checks++;
        if (done_cnt - d0 !== nw)
            $display("FAIL random_count: got %0d want %0d", done_cnt - d0, nw);
        else passes++;
        idle(30);
    endtask

    initial begin
        test_reset();
        test_directed(0, 8'h40, 8'h0F, 8'hF0, 8'h00, 8'hFF);
        test_directed(1, 8'h01, 8'hFF, 8'h00, 8'h40, 8'h0F);
        test_backpressure();
        test_reset_mid_busy();
        test_random(0, 1000);
        test_random(1, 1000);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
